dac_spi_streamer: RTL and testbench
===================================

// Module: dac_spi_streamer
// PURPOSE
//  Downstream stage of the waveform generators. Accepts one 12-bit sample pair (A,B) through a
//  valid/ready handshake and serialises it as two 32-bit write-and-update frames to the LTC2624
//  DAC over SPI (SCK, MOSI, CS, CLR). Paces the generator: a new sample is taken only when the
//  previous pair has been fully shifted out, so output frequency is set by upstream pacing alone.
// PARAMETERS
//  SCK_DIV  2        SCK half-period in CLK_50M cycles (>=1); SCK = 50 MHz/(2*SCK_DIV) = 12.5 MHz
//  CS_GAP   2        CLK_50M cycles DAC_CS is held high between frames and after the last frame (>=1)
//  CMD      4'b0011  LTC2624 command nibble (write and update)
//  ADDR_A   4'b0000  address nibble, first frame
//  ADDR_B   4'b0001  address nibble, second frame
//  DUAL     1        1: send A then B frames; 0: send only the A frame, sample_b ignored
// PORTS
//  CLK_50M       in   1   system clock, all logic on posedge
//  reset_n       in   1   asynchronous active-low reset
//  sample_a      in   12  channel A code (unsigned, 0x000..0xFFF)
//  sample_b      in   12  channel B code
//  sample_valid  in   1   upstream holds sample pair valid
//  sample_ready  out  1   block can accept a pair this cycle
//  busy          out  1   high from accept until the final CS_GAP expires
//  frame_done    out  1   1-cycle pulse when the last frame of a pair ends (DAC_CS rises)
//  SPI_SCK       out  1   SPI clock, idle low
//  SPI_MOSI      out  1   serial data, MSB first
//  DAC_CS        out  1   active-low chip select
//  DAC_CLR       out  1   active-low DAC clear
// BEHAVIOUR
//  - Reset (reset_n=0, async, any state): SCK=0, MOSI=0, CS=1, CLR=0, ready=0, busy=0,
//    frame_done=0; FSM->IDLE; frame aborted, no frame_done. Edge after release: CLR=1, ready=1.
//  - All outputs registered; no combinational path from inputs to outputs.
//  - FSM: IDLE -> SHIFT_A -> GAP_A -> SHIFT_B -> GAP_B -> IDLE (DUAL=0: SHIFT_A -> GAP_B).
//  - IDLE: ready=1. Accept on edge T when valid&ready; sample_a/b latched at T; later input
//    changes have no effect. ready=0 and busy=1 from T+1.
//  - Frame word {8'h00, CMD, ADDR, data[11:0], 4'h0}, 32 bits, MSB first.
//  - SHIFT: at T+1, CS=0, SCK=0, MOSI=bit31. Each bit = 2*SCK_DIV cycles: SCK low SCK_DIV
//    cycles, then high SCK_DIV cycles. MOSI changes only on the edge where SCK goes low,
//    stable for the full high phase (DAC samples on SCK rise). CS low exactly 64*SCK_DIV cycles.
//  - After bit0's high phase: same edge SCK=0, CS=1, MOSI=0. frame_done=1 for that one cycle
//    when it ends the last frame of the pair.
//  - GAP: CS high CS_GAP cycles. GAP_A -> SHIFT_B; GAP_B -> IDLE (ready=1, busy=0 same edge).
//  - Pair period (DUAL=1): 2*(64*SCK_DIV + CS_GAP) cycles accept-to-ready = 260 at defaults.
//  - valid held high continuously: next pair accepted in the first IDLE cycle (no idle bubble
//    beyond that cycle); valid while ready=0 ignored, not queued.
//  - Bit counter 5 bits, wraps 0->31 only via reload at frame start; no under/overflow path.
//  - DAC_CLR never asserted after reset release.
// TESTING
//  1 reset_n=0 mid-run -> SCK=0,CS=1,MOSI=0,CLR=0,ready=0 immediately; edge after release ready=1.
//  2 A=0xABC,B=0x123 one pulse -> frames 32'h0030ABC0 then 32'h00311230 captured on SCK rise,
//    CS low 128 cycles each, 2-cycle gap, frame_done at cycle 129+2+128, ready at accept+260.
//  3 valid held high, changing data each accept -> accepts exactly 260 cycles apart, every frame
//    carries the data latched at its own accept.
//  4 reset asserted after 10th SCK rise of frame A -> CS high at once, no frame_done, next pair
//    after release sent complete and correct.
//  5 A=0xFFF,B=0x000 -> 32'h0030FFF0 and 32'h00310000; SCK_DIV=1,CS_GAP=1 run -> pair in 130 cycles.
//  6 DUAL=0, A=0x800 -> single frame 32'h00308000, frame_done on its CS rise, ready after 130 cycles.

Source files
------------

// File: rtl/dac_spi_streamer_if.sv
// dac_spi_streamer_if: sample-pair valid/ready handshake into the DAC streamer
interface dac_spi_streamer_if;
  logic [11:0] sample_a;
  logic [11:0] sample_b;
  logic        sample_valid;
  logic        sample_ready;
  modport master (output sample_a, sample_b, sample_valid, input sample_ready);
  modport slave (input sample_a, sample_b, sample_valid, output sample_ready);
endinterface

// File: rtl/dac_spi_streamer.sv
// dac_spi_streamer: serialises (A,B) sample pairs into LTC2624 write-and-update SPI frames
module dac_spi_streamer #(
  parameter int       SCK_DIV = 2,
  parameter int       CS_GAP  = 2,
  parameter bit [3:0] CMD     = 4'b0011,
  parameter bit [3:0] ADDR_A  = 4'b0000,
  parameter bit [3:0] ADDR_B  = 4'b0001,
  parameter bit       DUAL    = 1'b1
) (
  input  logic              CLK_50M,
  input  logic              reset_n,
  dac_spi_streamer_if.slave sif,
  output logic              busy,
  output logic              frame_done,
  output logic              SPI_SCK,
  output logic              SPI_MOSI,
  output logic              DAC_CS,
  output logic              DAC_CLR
);
  localparam int DW = $clog2(SCK_DIV + 1);
  localparam int GW = $clog2(CS_GAP + 1);
  localparam logic [DW-1:0] DIV_END   = DW'(SCK_DIV - 1);
  localparam logic [GW-1:0] GAP_A_END = GW'(CS_GAP - 1);
  // The IDLE cycle completes the trailing gap, so back-to-back pairs keep CS high exactly CS_GAP cycles
  localparam logic [GW-1:0] GAP_B_END = GW'(CS_GAP > 1 ? CS_GAP - 2 : 0);
  typedef enum logic [2:0] {IDLE, SHIFT_A, GAP_A, SHIFT_B, GAP_B} state_t;
  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [GW-1:0] gap_q, gap_d;
  logic [4:0]    bit_q, bit_d;
  logic [31:0]   sr_q, sr_d;
  logic [11:0]   b_q, b_d;
  logic          sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d, clr_q;
  logic          ready_q, ready_d, busy_q, busy_d, done_q, done_d;
  logic [31:0]   word;
  logic          load, last;
  function automatic logic [31:0] frame(input logic [3:0] addr, input logic [11:0] data);
    return {8'h00, CMD, addr, data, 4'h0};
  endfunction
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    gap_d   = gap_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    b_d     = b_q;
    sck_d   = sck_q;
    mosi_d  = mosi_q;
    cs_d    = cs_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;
    last    = state_q == SHIFT_B || !DUAL;
    word    = state_q == IDLE ? frame(ADDR_A, sif.sample_a) : frame(ADDR_B, b_q);
    case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        if (sif.sample_valid && ready_q) begin
          state_d = SHIFT_A;
          ready_d = 1'b0;
          busy_d  = 1'b1;
          b_d     = sif.sample_b;
          load    = 1'b1;
        end
      end
      SHIFT_A, SHIFT_B: begin
        if (div_q != DIV_END) div_d = div_q + 1'b1;
        else begin
          div_d = '0;
          sck_d = !sck_q;
          if (sck_q && bit_q == 5'd0) begin
            cs_d    = 1'b1;
            mosi_d  = 1'b0;
            gap_d   = '0;
            done_d  = last;
            state_d = !last ? GAP_A : CS_GAP == 1 ? IDLE : GAP_B;
            ready_d = last && CS_GAP == 1;
            busy_d  = !(last && CS_GAP == 1);
          end else if (sck_q) begin
            bit_d  = bit_q - 1'b1;
            mosi_d = sr_q[31];
            sr_d   = {sr_q[30:0], 1'b0};
          end
        end
      end
      GAP_A: begin
        if (gap_q == GAP_A_END) begin
          state_d = SHIFT_B;
          load    = 1'b1;
        end else gap_d = gap_q + 1'b1;
      end
      GAP_B: begin
        if (gap_q == GAP_B_END) begin
          state_d = IDLE;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (load) begin
      cs_d   = 1'b0;
      sck_d  = 1'b0;
      div_d  = '0;
      bit_d  = 5'd31;
      mosi_d = word[31];
      sr_d   = {word[30:0], 1'b0};
    end
  end
  always_ff @(posedge CLK_50M or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      div_q   <= '0;
      gap_q   <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      b_q     <= '0;
      sck_q   <= 1'b0;
      mosi_q  <= 1'b0;
      cs_q    <= 1'b1;
      clr_q   <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      gap_q   <= gap_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      b_q     <= b_d;
      sck_q   <= sck_d;
      mosi_q  <= mosi_d;
      cs_q    <= cs_d;
      clr_q   <= 1'b1;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
  assign sif.sample_ready = ready_q;
  assign busy       = busy_q;
  assign frame_done = done_q;
  assign SPI_SCK    = sck_q;
  assign SPI_MOSI   = mosi_q;
  assign DAC_CS     = cs_q;
  assign DAC_CLR    = clr_q;
endmodule

// File: tb/tb_dac_spi_streamer.sv
// tb_dac_spi_streamer: scoreboarded SPI frame capture for three parameterisations of the streamer
module tb_dac_spi_streamer;
  typedef struct packed {
    logic [11:0] a;
    logic [11:0] b;
    logic [31:0] wa;
    logic [31:0] wb;
  } vec_t;
  logic        clk = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  logic [2:0]  rst_n, valid, ready, busy, done, sck, mosi, cs, clr;
  logic [11:0] sa [3];
  logic [11:0] sb [3];
  logic [32:0] exp_q [3][$];
  vec_t        vt [6];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic void chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s dut%0d: got 0x%0h expected 0x%0h at t=%0t", nm, i, act, req, $time);
    end
  endfunction
  // dut0: defaults, dut1: SCK_DIV=1 CS_GAP=1, dut2: DUAL=0
  for (genvar g = 0; g < 3; g++) begin : gd
    localparam int SD = g == 1 ? 1 : 2;
    localparam int CG = g == 1 ? 1 : 2;
    localparam bit DL = g != 2;
    dac_spi_streamer_if bus ();
    assign bus.sample_a     = sa[g];
    assign bus.sample_b     = sb[g];
    assign bus.sample_valid = valid[g];
    assign ready[g]         = bus.sample_ready;
    dac_spi_streamer #(.SCK_DIV(SD), .CS_GAP(CG), .DUAL(DL)) dut (
      .CLK_50M(clk), .reset_n(rst_n[g]), .sif(bus), .busy(busy[g]), .frame_done(done[g]),
      .SPI_SCK(sck[g]), .SPI_MOSI(mosi[g]), .DAC_CS(cs[g]), .DAC_CLR(clr[g]));
    int          nb = 0, lo = 0, hi = 1000;
    logic [31:0] sh = '0;
    logic        pcs = 1'b1, psck = 1'b0, pm = 1'b0, plast = 1'b1;
    logic [32:0] e;
    always @(negedge clk) begin
      if (!rst_n[g]) begin
        nb = 0; lo = 0; hi = 1000; pcs = 1'b1; psck = 1'b0; plast = 1'b1;
      end else begin
        if (sck[g] && psck) chk("mosi_stable_sck_high", g, 32'(mosi[g]), 32'(pm));
        if (!cs[g] && pcs) begin
          if (plast) chk("cs_gap_min", g, 32'(hi >= CG), 1);
          else chk("cs_gap", g, hi, CG);
          lo = 0; nb = 0;
        end
        if (!cs[g] && sck[g] && !psck) begin sh = {sh[30:0], mosi[g]}; nb++; end
        if (cs[g] && !pcs) begin
          if (exp_q[g].size() == 0) chk("unexpected_frame", g, 1, 0);
          else begin
            e = exp_q[g].pop_front();
            chk("frame_word", g, sh, e[31:0]);
            chk("frame_done", g, 32'(done[g]), 32'(e[32]));
            plast = e[32];
          end
          chk("sck_rises", g, nb, 32);
          chk("cs_low_cycles", g, lo, 64 * SD);
          chk("sck_at_cs_rise", g, 32'(sck[g]), 0);
          chk("mosi_at_cs_rise", g, 32'(mosi[g]), 0);
          hi = 0;
        end else if (done[g]) chk("spurious_done", g, 32'(done[g]), 0);
        if (!cs[g]) lo++; else hi++;
        psck = sck[g]; pcs = cs[g]; pm = mosi[g];
      end
    end
  end
  task automatic send(input int i, input int k, input bit hold, output int t);
    bit ok = 1'b0;
    @(negedge clk);
    sa[i] = vt[k].a; sb[i] = vt[k].b; valid[i] = 1'b1;
    if (i != 2) begin
      exp_q[i].push_back({1'b0, vt[k].wa});
      exp_q[i].push_back({1'b1, vt[k].wb});
    end else exp_q[i].push_back({1'b1, vt[k].wa});
    for (int n = 0; n < 1000 && !ok; n++) begin
      if (ready[i]) begin @(posedge clk); #1; ok = 1'b1; end
      else @(negedge clk);
    end
    t = cyc;
    if (!ok) chk("accept_timeout", i, 0, 1);
    else begin
      chk("busy_after_accept", i, 32'(busy[i]), 1);
      chk("ready_after_accept", i, 32'(ready[i]), 0);
    end
    sa[i] = sa[i] ^ 12'h5A5; sb[i] = ~sb[i]; valid[i] = hold;
  endtask
  task automatic wait_idle(input int i);
    int n = 0;
    while (busy[i] && n < 2000) begin @(negedge clk); n++; end
    if (busy[i]) chk("idle_timeout", i, 1, 0);
  endtask
  initial begin
    int t1, t2, t3, n;
    logic prev;
    vt[0] = '{12'hABC, 12'h123, 32'h0030ABC0, 32'h00311230};
    vt[1] = '{12'hFFF, 12'h000, 32'h0030FFF0, 32'h00310000};
    vt[2] = '{12'h555, 12'hAAA, 32'h00305550, 32'h0031AAA0};
    vt[3] = '{12'h001, 12'h800, 32'h00300010, 32'h00318000};
    vt[4] = '{12'h800, 12'h7FF, 32'h00308000, 32'h00317FF0};
    vt[5] = '{12'h3C5, 12'h0F0, 32'h00303C50, 32'h003100F0};
    valid = '0; rst_n = '1;
    for (int i = 0; i < 3; i++) begin sa[i] = '0; sb[i] = '0; end
    #1 rst_n = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("rst_cs", i, 32'(cs[i]), 1);
      chk("rst_clr", i, 32'(clr[i]), 0);
      chk("rst_ready", i, 32'(ready[i]), 0);
    end
    chk("rst_sck", 0, 32'(sck[0]), 0);
    chk("rst_mosi", 0, 32'(mosi[0]), 0);
    chk("rst_busy", 0, 32'(busy[0]), 0);
    #2 rst_n = '1;
    @(posedge clk); #1;
    for (int i = 0; i < 3; i++) begin
      chk("release_ready", i, 32'(ready[i]), 1);
      chk("release_clr", i, 32'(clr[i]), 1);
    end
    send(0, 0, 1'b0, t1);
    wait_idle(0);
    send(0, 1, 1'b1, t1);
    send(0, 2, 1'b1, t2);
    send(0, 3, 1'b0, t3);
    chk("accept_interval", 0, t2 - t1, 260);
    chk("accept_interval", 0, t3 - t2, 260);
    wait_idle(0);
    send(0, 5, 1'b0, t1);
    n = 0; prev = 1'b0;
    for (int c = 0; c < 400 && n < 10; c++) begin
      @(negedge clk);
      if (sck[0] && !prev) n++;
      prev = sck[0];
    end
    if (n < 10) chk("sck_rise_timeout", 0, n, 10);
    #1 rst_n[0] = 1'b0;
    #1;
    chk("abort_sck", 0, 32'(sck[0]), 0);
    chk("abort_cs", 0, 32'(cs[0]), 1);
    chk("abort_mosi", 0, 32'(mosi[0]), 0);
    chk("abort_clr", 0, 32'(clr[0]), 0);
    chk("abort_ready", 0, 32'(ready[0]), 0);
    chk("abort_busy", 0, 32'(busy[0]), 0);
    chk("abort_done", 0, 32'(done[0]), 0);
    exp_q[0].delete();
    @(negedge clk); #2 rst_n[0] = 1'b1;
    @(posedge clk); #1;
    chk("rerelease_ready", 0, 32'(ready[0]), 1);
    chk("rerelease_clr", 0, 32'(clr[0]), 1);
    send(0, 4, 1'b0, t1);
    wait_idle(0);
    send(1, 1, 1'b1, t1);
    send(1, 0, 1'b0, t2);
    chk("accept_interval", 1, t2 - t1, 130);
    wait_idle(1);
    send(2, 4, 1'b1, t1);
    send(2, 2, 1'b0, t2);
    chk("accept_interval", 2, t2 - t1, 130);
    wait_idle(2);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) chk("frames_outstanding", i, exp_q[i].size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
